// File: rtl/mole_game_ctrl.sv
// Whack-a-mole controller: LFSR-driven mole placement, per-mole timing, hit/miss judging, BCD score.
// Optional MISS_PENALTY_EN: a miss or timeout costs one point, saturating at 00.
module mole_game_ctrl #(
   parameter int unsigned MOLE_TICKS     = 100_000_000,
   parameter int unsigned FEEDBACK_TICKS = 50_000_000,
   parameter int unsigned ROUNDS         = 20
) (
   input  logic       master_clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] btn,
   output logic [2:0] mole_position,
   output logic       guess_correct,
   output logic       guess_wrong,
   output logic [3:0] digit_1,
   output logic [3:0] digit_2,
   output logic       game_over
);

   localparam int unsigned MaxTicks = (MOLE_TICKS > FEEDBACK_TICKS) ? MOLE_TICKS : FEEDBACK_TICKS;
   localparam int unsigned TW = $clog2(MaxTicks + 1);
   localparam int unsigned RW = $clog2(ROUNDS + 1);

   localparam logic [TW-1:0] MoleLast = TW'(MOLE_TICKS - 1);
   localparam logic [TW-1:0] FbLast   = TW'(FEEDBACK_TICKS - 1);
   localparam logic [RW-1:0] RoundsW  = RW'(ROUNDS);

   localparam logic [1:0] StIdle     = 2'd0;
   localparam logic [1:0] StShow     = 2'd1;
   localparam logic [1:0] StFeedback = 2'd2;
   localparam logic [1:0] StOver     = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [7:0]    lfsr_q, lfsr_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [RW-1:0] round_q, round_d, round_inc;
   logic [2:0]    mole_q, mole_d, cand, next_mole;
   logic          correct_q, correct_d, wrong_q, wrong_d, over_q, over_d;
   logic [3:0]    tens_q, tens_d, ones_q, ones_d;
   logic [3:0]    inc_tens, inc_ones, miss_tens, miss_ones;
   logic [7:0]    hit_mask;

   // Taps 8,6,5,4 with a left shift; a nonzero seed keeps the sequence off zero
   assign lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   assign cand      = lfsr_q[2:0];
   assign next_mole = (cand == mole_q) ? cand + 3'd1 : cand;
   assign hit_mask  = 8'd1 << mole_q;
   assign round_inc = round_q + RW'(1);

   always_comb begin
      inc_tens = tens_q;
      inc_ones = ones_q;
      if (!(tens_q == 4'd9 && ones_q == 4'd9)) begin
         if (ones_q == 4'd9) begin
            inc_ones = 4'd0;
            inc_tens = tens_q + 4'd1;
         end else begin
            inc_ones = ones_q + 4'd1;
         end
      end
   end

`ifdef MISS_PENALTY_EN
   always_comb begin
      miss_tens = tens_q;
      miss_ones = ones_q;
      if (!(tens_q == 4'd0 && ones_q == 4'd0)) begin
         if (ones_q == 4'd0) begin
            miss_ones = 4'd9;
            miss_tens = tens_q - 4'd1;
         end else begin
            miss_ones = ones_q - 4'd1;
         end
      end
   end
`else
   assign miss_tens = tens_q;
   assign miss_ones = ones_q;
`endif

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      round_d   = round_q;
      mole_d    = mole_q;
      correct_d = correct_q;
      wrong_d   = wrong_q;
      tens_d    = tens_q;
      ones_d    = ones_q;
      over_d    = over_q;
      case (state_q)
         StIdle, StOver: begin
            if (start) begin
               tens_d  = 4'd0;
               ones_d  = 4'd0;
               round_d = '0;
               mole_d  = next_mole;
               timer_d = '0;
               over_d  = 1'b0;
               state_d = StShow;
            end
         end
         StShow: begin
            // Any press outranks a same-cycle timeout
            if (btn != 8'd0) begin
               timer_d = '0;
               state_d = StFeedback;
               if (btn == hit_mask) begin
                  correct_d = 1'b1;
                  tens_d    = inc_tens;
                  ones_d    = inc_ones;
               end else begin
                  wrong_d = 1'b1;
                  tens_d  = miss_tens;
                  ones_d  = miss_ones;
               end
            end else if (timer_q == MoleLast) begin
               timer_d = '0;
               state_d = StFeedback;
               wrong_d = 1'b1;
               tens_d  = miss_tens;
               ones_d  = miss_ones;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         StFeedback: begin
            if (timer_q == FbLast) begin
               correct_d = 1'b0;
               wrong_d   = 1'b0;
               round_d   = round_inc;
               timer_d   = '0;
               if (round_inc == RoundsW) begin
                  mole_d  = 3'd0;
                  over_d  = 1'b1;
                  state_d = StOver;
               end else begin
                  mole_d  = next_mole;
                  state_d = StShow;
               end
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge master_clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         lfsr_q    <= 8'hA5;
         timer_q   <= '0;
         round_q   <= '0;
         mole_q    <= 3'd0;
         correct_q <= 1'b0;
         wrong_q   <= 1'b0;
         tens_q    <= 4'd0;
         ones_q    <= 4'd0;
         over_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         lfsr_q    <= lfsr_d;
         timer_q   <= timer_d;
         round_q   <= round_d;
         mole_q    <= mole_d;
         correct_q <= correct_d;
         wrong_q   <= wrong_d;
         tens_q    <= tens_d;
         ones_q    <= ones_d;
         over_q    <= over_d;
      end
   end

   assign mole_position = mole_q;
   assign guess_correct = correct_q;
   assign guess_wrong   = wrong_q;
   assign digit_1       = tens_q;
   assign digit_2       = ones_q;
   assign game_over     = over_q;

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Bench for mole_game_ctrl: directed vector table, timeout/score corner sequences, and random
// play against an integer-score reference model. Honours MISS_PENALTY_EN.
module tb_mole_game_ctrl;

   localparam int MT = 10;
   localparam int FT = 4;
   localparam int R  = 3;
   localparam int RL = 110;

   localparam int PhIdle = 0;
   localparam int PhShow = 1;
   localparam int PhFb   = 2;
   localparam int PhOver = 3;

`ifdef MISS_PENALTY_EN
   localparam int AfterMiss = 0;
`else
   localparam int AfterMiss = 1;
`endif

   logic       master_clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] btn = 8'd0;
   logic [2:0] mole_position;
   logic       guess_correct, guess_wrong, game_over;
   logic [3:0] digit_1, digit_2;

   logic       start_l = 1'b0;
   logic [7:0] btn_l = 8'd0;
   logic [2:0] mole_position_l;
   logic       guess_correct_l, guess_wrong_l, game_over_l;
   logic [3:0] digit_1_l, digit_2_l;

   always #5 master_clk = ~master_clk;

   mole_game_ctrl #(.MOLE_TICKS(MT), .FEEDBACK_TICKS(FT), .ROUNDS(R)) dut (
      .master_clk(master_clk), .rst(rst), .start(start), .btn(btn),
      .mole_position(mole_position), .guess_correct(guess_correct), .guess_wrong(guess_wrong),
      .digit_1(digit_1), .digit_2(digit_2), .game_over(game_over)
   );

   mole_game_ctrl #(.MOLE_TICKS(MT), .FEEDBACK_TICKS(FT), .ROUNDS(RL)) dut_long (
      .master_clk(master_clk), .rst(rst), .start(start_l), .btn(btn_l),
      .mole_position(mole_position_l), .guess_correct(guess_correct_l),
      .guess_wrong(guess_wrong_l), .digit_1(digit_1_l), .digit_2(digit_2_l),
      .game_over(game_over_l)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: score kept as a plain integer 0..99
   int m_phase, m_lfsr, m_mole, m_score, m_elapsed, m_rounds;
   bit m_cor, m_wrong, m_over;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = PhIdle; m_lfsr = 8'hA5; m_mole = 0; m_score = 0;
      m_elapsed = 0; m_rounds = 0; m_cor = 0; m_wrong = 0; m_over = 0;
   endtask

   function automatic int lfsr_next(input int l);
      int fb;
      fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
      return ((l << 1) | fb) & 255;
   endfunction

   function automatic int pick_mole();
      int c;
      c = m_lfsr % 8;
      return (c == m_mole) ? (c + 1) % 8 : c;
   endfunction

   task automatic model_miss();
      m_wrong = 1;
`ifdef MISS_PENALTY_EN
      if (m_score > 0) m_score--;
`endif
   endtask

   task automatic model_edge(input bit s, input logic [7:0] b);
      int nl;
      logic [7:0] one;
      nl  = lfsr_next(m_lfsr);
      one = 8'd1;
      case (m_phase)
         PhIdle, PhOver: if (s) begin
            m_score = 0; m_rounds = 0; m_mole = pick_mole(); m_elapsed = 0;
            m_over = 0; m_phase = PhShow;
         end
         PhShow: begin
            if (b != 8'd0) begin
               m_elapsed = 0; m_phase = PhFb;
               if (b == (one << m_mole)) begin
                  m_cor = 1;
                  if (m_score < 99) m_score++;
               end else model_miss();
            end else if (m_elapsed == MT - 1) begin
               m_elapsed = 0; m_phase = PhFb; model_miss();
            end else m_elapsed++;
         end
         default: begin
            if (m_elapsed == FT - 1) begin
               m_cor = 0; m_wrong = 0; m_rounds++; m_elapsed = 0;
               if (m_rounds == R) begin
                  m_phase = PhOver; m_over = 1; m_mole = 0;
               end else begin
                  m_mole = pick_mole(); m_phase = PhShow;
               end
            end else m_elapsed++;
         end
      endcase
      m_lfsr = nl;
   endtask

   task automatic check_model(input string tag);
      check({tag, "_mole"}, int'(mole_position), m_mole);
      check({tag, "_correct"}, int'(guess_correct), int'(m_cor));
      check({tag, "_wrong"}, int'(guess_wrong), int'(m_wrong));
      check({tag, "_tens"}, int'(digit_1), m_score / 10);
      check({tag, "_ones"}, int'(digit_2), m_score % 10);
      check({tag, "_over"}, int'(game_over), int'(m_over));
   endtask

   task automatic cycle(input bit s, input logic [7:0] b, input string tag);
      start = s;
      btn   = b;
      @(posedge master_clk);
      model_edge(s, b);
      #1;
      start = 1'b0;
      btn   = 8'd0;
      check_model(tag);
   endtask

   // Called just after a rising edge: reset lands mid-cycle, outputs checked before the next edge
   task automatic async_reset();
      #2 rst = 1'b0;
      #1 model_reset();
      check_model("async_rst");
      check("async_rst_all_zero",
            int'({mole_position, guess_correct, guess_wrong, digit_1, digit_2, game_over}), 0);
      #2 rst = 1'b1;
   endtask

   function automatic logic [7:0] press(input int kind);
      logic [7:0] one;
      one = 8'd1;
      case (kind)
         1: return one << m_mole;
         2: return one << ((m_mole + 3) % 8);
         3: return (one << m_mole) | (one << ((m_mole + 1) % 8));
         default: return 8'd0;
      endcase
   endfunction

   typedef struct {
      bit s; int kind; bit ec; bit ew; int et; int eo; bit eov;
   } vec_t;

   vec_t tbl[18];

   initial begin
      int prev;
      logic [7:0] one;
      one = 8'd1;
      // kind: 0 none, 1 hit, 2 wrong single, 3 two buttons
      tbl[0]  = '{1, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{0, 1, 1, 0, 0, 1, 0};
      tbl[2]  = '{0, 0, 1, 0, 0, 1, 0};
      tbl[3]  = '{0, 2, 1, 0, 0, 1, 0};
      tbl[4]  = '{1, 0, 1, 0, 0, 1, 0};
      tbl[5]  = '{0, 0, 0, 0, 0, 1, 0};
      tbl[6]  = '{0, 2, 0, 1, 0, AfterMiss, 0};
      tbl[7]  = '{0, 0, 0, 1, 0, AfterMiss, 0};
      tbl[8]  = '{0, 0, 0, 1, 0, AfterMiss, 0};
      tbl[9]  = '{0, 0, 0, 1, 0, AfterMiss, 0};
      tbl[10] = '{0, 0, 0, 0, 0, AfterMiss, 0};
      tbl[11] = '{0, 3, 0, 1, 0, AfterMiss, 0};
      tbl[12] = '{1, 0, 0, 1, 0, AfterMiss, 0};
      tbl[13] = '{0, 1, 0, 1, 0, AfterMiss, 0};
      tbl[14] = '{0, 0, 0, 1, 0, AfterMiss, 0};
      tbl[15] = '{0, 0, 0, 0, 0, AfterMiss, 1};
      tbl[16] = '{0, 1, 0, 0, 0, AfterMiss, 1};
      tbl[17] = '{1, 0, 0, 0, 0, 0, 0};

      model_reset();
      #2 rst = 1'b0;
      #1 check_model("reset");
      @(negedge master_clk);
      @(negedge master_clk);
      check_model("reset_hold");
      rst = 1'b1;

      cycle(0, 8'hFF, "idle_btn");
      for (int i = 0; i < 18; i++) begin
         prev = m_mole;
         cycle(tbl[i].s, press(tbl[i].kind), "tbl");
         check($sformatf("tbl%0d_correct", i), int'(guess_correct), int'(tbl[i].ec));
         check($sformatf("tbl%0d_wrong", i), int'(guess_wrong), int'(tbl[i].ew));
         check($sformatf("tbl%0d_tens", i), int'(digit_1), tbl[i].et);
         check($sformatf("tbl%0d_ones", i), int'(digit_2), tbl[i].eo);
         check($sformatf("tbl%0d_over", i), int'(game_over), int'(tbl[i].eov));
         if (i == 5) check("new_mole_differs", int'(mole_position != 3'(prev)), 1);
      end

      cycle(0, 8'd0, "pre_rst");
      async_reset();
      for (int i = 0; i < 3; i++) cycle(0, 8'hFF, "post_rst_idle");
      check("post_rst_needs_start", int'(guess_correct | guess_wrong | game_over), 0);

      // Timeout on the 10th silent SHOW cycle, then a hit on the 10th cycle of the next mole
      cycle(1, 8'd0, "to_start");
      for (int i = 0; i < MT - 1; i++) cycle(0, 8'd0, "to_wait");
      check("timeout_early", int'(guess_wrong), 0);
      cycle(0, 8'd0, "to_fire");
      check("timeout_wrong", int'(guess_wrong), 1);
      for (int i = 0; i < FT; i++) cycle(0, 8'd0, "to_fb");
      for (int i = 0; i < MT - 1; i++) cycle(0, 8'd0, "late_wait");
      cycle(0, press(1), "late_hit");
      check("late_hit_correct", int'(guess_correct), 1);
      check("late_hit_not_wrong", int'(guess_wrong), 0);

      for (int i = 0; i < 3000; i++) begin
         logic [7:0] b;
         int r;
         r = $urandom_range(0, 9);
         if (r < 6) b = 8'd0;
         else if (r < 8) b = press(1);
         else if (r == 8) b = one << $urandom_range(0, 7);
         else b = 8'($urandom);
         cycle($urandom_range(0, 15) == 0, b, "rand");
         if ($urandom_range(0, 499) == 0) async_reset();
      end

      // Long game: climb to 99 and beyond on a second instance
      start_l = 1'b1;
      cycle(0, 8'd0, "long_start");
      start_l = 1'b0;
      check("long_start_score", int'({digit_1_l, digit_2_l}), 0);
      for (int k = 1; k <= 101; k++) begin
         int exp;
         prev  = int'(mole_position_l);
         btn_l = one << mole_position_l;
         cycle(0, 8'd0, "long_bg");
         btn_l = 8'd0;
         exp   = (k > 99) ? 99 : k;
         check($sformatf("long%0d_correct", k), int'(guess_correct_l), 1);
         check($sformatf("long%0d_tens", k), int'(digit_1_l), exp / 10);
         check($sformatf("long%0d_ones", k), int'(digit_2_l), exp % 10);
         for (int j = 0; j < FT; j++) cycle(0, 8'd0, "long_bg");
         check($sformatf("long%0d_flag_clear", k), int'(guess_correct_l), 0);
         check($sformatf("long%0d_mole_moved", k), int'(mole_position_l != 3'(prev)), 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
